uart_host_seq: RTL and testbench
================================

UART_HOST_SEQ -- requirements
Module: uart_host_seq

Interface
REQ-001 The module SHALL provide parameter SIZEDATA, default 8, operand/result byte width.
REQ-002 The module SHALL provide parameter SIZEOP, default 6, opcode width; the opcode is zero-extended to SIZEDATA on the line.
REQ-003 The module SHALL provide parameter TICKS_PER_BIT, default 16, i_tick pulses per serial bit.
REQ-004 The module SHALL provide parameter TIMEOUT_BITS, default 64, bit-times to wait for a result start bit.
REQ-005 The module SHALL have port i_clock, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port i_reset, input, 1, synchronous, active-high reset.
REQ-007 The module SHALL have port i_tick, input, 1, one-cycle baud-rate-generator pulse.
REQ-008 The module SHALL have port i_start, input, 1, single-cycle request to run one transaction.
REQ-009 The module SHALL have ports i_datoa and i_datob, input, SIZEDATA each, operands A and B.
REQ-010 The module SHALL have port i_opcode, input, SIZEOP, ALU opcode.
REQ-011 The module SHALL have port i_rx_data_input, input, 1, serial line from the far-end transmitter.
REQ-012 The module SHALL have port o_tx_data, output, 1, serial line to the far-end receiver; idle high.
REQ-013 The module SHALL have ports o_busy (1), o_done (1), o_result (SIZEDATA), o_frame_err (1), o_parity_err (1) and o_timeout (1), all outputs.

Function
REQ-014 Every frame SHALL be: start 0, SIZEDATA data bits LSB first, even parity (XOR of the data bits), stop 1; each bit lasts exactly TICKS_PER_BIT i_tick pulses.
REQ-015 The FSM SHALL use states IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_PARITY, RX_STOP and DONE.
REQ-016 In IDLE, i_start=1 SHALL capture i_datoa, i_datob and i_opcode, set o_busy=1, clear all three error flags, and enter TX_START on the next cycle.
REQ-017 i_start SHALL be ignored whenever o_busy=1.
REQ-018 The module SHALL transmit three frames back-to-back, in order A, B, opcode, with no idle gap; a 2-bit byte index selects the byte.
REQ-019 After the third stop bit the module SHALL enter RX_WAIT with o_tx_data=1.
REQ-020 In RX_WAIT, a 0 on i_rx_data_input SHALL enter RX_START; if TIMEOUT_BITS*TICKS_PER_BIT ticks pass first, o_timeout SHALL be set and the FSM SHALL enter DONE.
REQ-021 RX_START SHALL resample the line at tick TICKS_PER_BIT/2; if it reads 1 (glitch), the FSM SHALL return to RX_WAIT without restarting the timeout count.
REQ-022 The data, parity and stop bits SHALL each be sampled TICKS_PER_BIT ticks after the previous sample point, that is, at mid-bit.
REQ-023 A stop-bit sample of 0 SHALL set o_frame_err; the FSM SHALL still enter DONE.
REQ-024 In DONE, o_result SHALL take the received byte (left unchanged on timeout), o_done SHALL pulse high for exactly one cycle, o_busy SHALL fall, and the FSM SHALL return to IDLE.
REQ-025 o_result and the error flags SHALL hold their values until the next accepted i_start or reset.
REQ-026 Counters SHALL advance only on cycles where i_tick=1.

Reset
REQ-027 i_reset=1 SHALL, on the next clock edge and in any state including mid-frame, force IDLE with o_tx_data=1, o_busy=0, o_done=0, o_result=0, all error flags 0, and all counters 0.
REQ-028 If i_reset and i_start are high in the same cycle, reset SHALL win and the request SHALL be dropped.

Configuration
REQ-029 With HOST_PARITY_CHECK_EN defined, a received parity bit that differs from the XOR of the received data SHALL set o_parity_err in DONE.
REQ-030 Without HOST_PARITY_CHECK_EN, the parity bit SHALL be sampled and discarded, and o_parity_err SHALL be tied to 0.

Verification
REQ-031 A=0x02, B=0x04, op=0x20; far-end model replies 0x06 with parity 0 -> o_result=0x06, one-cycle o_done, no error flags.
REQ-032 First frame on o_tx_data -> 0,0,1,0,0,0,0,0,0,1,1, each level held 16 ticks; frames 2 and 3 follow with no gap.
REQ-033 No reply after the opcode frame -> o_timeout=1 and o_done pulses exactly 1024 ticks after the third stop bit ends.
REQ-034 Reply 0x06 with parity 1 -> o_parity_err=1 with HOST_PARITY_CHECK_EN defined, 0 without; in both builds o_result=0x06.
REQ-035 Reply with stop bit 0, and separately a 4-tick low glitch in RX_WAIT -> the first gives o_frame_err=1; the second is rejected and the later real reply is received correctly.
REQ-036 Reset asserted during the data bits of frame 2, and i_start pulsed while busy -> after reset o_tx_data=1 and o_busy=0 on the next cycle; the busy-time i_start causes no second transaction.

Source files
------------

// File: rtl/uart_host_seq.sv
// Host-side UART sequencer: sends operand A, operand B and an opcode as three
// parity frames, then waits for one result frame. Optional build macro: HOST_PARITY_CHECK_EN.
module uart_host_seq #(
  parameter int SIZEDATA      = 8,
  parameter int SIZEOP        = 6,
  parameter int TICKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS  = 64
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_tick,
  input  logic                i_start,
  input  logic [SIZEDATA-1:0] i_datoa,
  input  logic [SIZEDATA-1:0] i_datob,
  input  logic [SIZEOP-1:0]   i_opcode,
  input  logic                i_rx_data_input,
  output logic                o_tx_data,
  output logic                o_busy,
  output logic                o_done,
  output logic [SIZEDATA-1:0] o_result,
  output logic                o_frame_err,
  output logic                o_parity_err,
  output logic                o_timeout,
  output logic [3:0]          o_dbg_state
);

  localparam int TO_LIMIT = TIMEOUT_BITS * TICKS_PER_BIT;
  localparam int TW       = $clog2(TICKS_PER_BIT + 1);
  localparam int BW       = $clog2(SIZEDATA + 1);
  localparam int TOW      = $clog2(TO_LIMIT + 1);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP,
    RX_WAIT, RX_START, RX_DATA, RX_PARITY, RX_STOP, DONE
  } state_t;

  state_t              state, state_next;
  logic [TW-1:0]       tick_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [1:0]          byte_idx;
  logic [TOW-1:0]      to_cnt;
  logic [SIZEDATA-1:0] reg_a, reg_b, reg_op, cur_byte, tx_shift, rx_shift;
  logic                bit_end, mid_tick, last_bit, to_end;
`ifdef HOST_PARITY_CHECK_EN
  logic                rx_par;
`endif

  assign bit_end     = i_tick && (tick_cnt == TW'(TICKS_PER_BIT - 1));
  assign mid_tick    = i_tick && (tick_cnt == TW'(TICKS_PER_BIT / 2 - 1));
  assign last_bit    = (bit_cnt == BW'(SIZEDATA - 1));
  assign to_end      = i_tick && (to_cnt == TOW'(TO_LIMIT - 1));
  assign o_done      = (state == DONE);
  assign o_dbg_state = state;

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = reg_a;
      2'd1:    cur_byte = reg_b;
      default: cur_byte = reg_op;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_tx_data  = 1'b1;
    case (state)
      IDLE:      if (i_start) state_next = TX_START;
      TX_START:  begin
                   o_tx_data = 1'b0;
                   if (bit_end) state_next = TX_DATA;
                 end
      TX_DATA:   begin
                   o_tx_data = tx_shift[0];
                   if (bit_end && last_bit) state_next = TX_PARITY;
                 end
      TX_PARITY: begin
                   o_tx_data = ^cur_byte;
                   if (bit_end) state_next = TX_STOP;
                 end
      TX_STOP:   if (bit_end) state_next = (byte_idx == 2'd2) ? RX_WAIT : TX_START;
      // A low line wins over an expiring timeout in the same cycle.
      RX_WAIT:   if (!i_rx_data_input) state_next = RX_START;
                 else if (to_end)      state_next = DONE;
      RX_START:  if (mid_tick) state_next = i_rx_data_input ? RX_WAIT : RX_DATA;
      RX_DATA:   if (bit_end && last_bit) state_next = RX_PARITY;
      RX_PARITY: if (bit_end) state_next = RX_STOP;
      RX_STOP:   if (bit_end) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      to_cnt      <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      reg_op      <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      o_busy      <= 1'b0;
      o_result    <= '0;
      o_frame_err <= 1'b0;
      o_timeout   <= 1'b0;
`ifdef HOST_PARITY_CHECK_EN
      rx_par       <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      // Tick counter restarts on every state change so each bit is timed from its own edge.
      if (state_next != state || state == IDLE || state == RX_WAIT || state == DONE)
        tick_cnt <= '0;
      else if (i_tick)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

      if (state != TX_DATA && state != RX_DATA) bit_cnt <= '0;
      else if (bit_end) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;

      if (state == IDLE) byte_idx <= '0;
      else if (state == TX_STOP && bit_end) byte_idx <= byte_idx + 1'b1;

      // Timeout count survives glitch rejections; only a new transaction clears it.
      if (state == IDLE) to_cnt <= '0;
      else if (state == RX_WAIT && i_tick) to_cnt <= to_cnt + 1'b1;

      if (state == TX_START && bit_end) tx_shift <= cur_byte;
      else if (state == TX_DATA && bit_end) tx_shift <= tx_shift >> 1;

      if (state == RX_DATA && bit_end) rx_shift <= {i_rx_data_input, rx_shift[SIZEDATA-1:1]};

      if (state == IDLE && i_start) begin
        reg_a       <= i_datoa;
        reg_b       <= i_datob;
        reg_op      <= SIZEDATA'(i_opcode);
        o_busy      <= 1'b1;
        o_frame_err <= 1'b0;
        o_timeout   <= 1'b0;
`ifdef HOST_PARITY_CHECK_EN
        o_parity_err <= 1'b0;
`endif
      end

      if (state == RX_WAIT && state_next == DONE) o_timeout <= 1'b1;
      if (state == RX_STOP && bit_end) o_frame_err <= !i_rx_data_input;
`ifdef HOST_PARITY_CHECK_EN
      if (state == RX_PARITY && bit_end) rx_par <= i_rx_data_input;
`endif

      if (state == DONE) begin
        o_busy <= 1'b0;
        if (!o_timeout) begin
          o_result <= rx_shift;
`ifdef HOST_PARITY_CHECK_EN
          o_parity_err <= rx_par ^ (^rx_shift);
`endif
        end
      end
    end
  end

`ifndef HOST_PARITY_CHECK_EN
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_host_seq.sv
// Directed bench for uart_host_seq: table of request/reply vectors plus
// hand-written timeout, reset-mid-frame and reset-vs-start sequences.
module tb_uart_host_seq;

`ifdef HOST_PARITY_CHECK_EN
  localparam logic PCHK = 1'b1;
`else
  localparam logic PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick, start, rx;
  logic [7:0] data_a, data_b;
  logic [5:0] opcode;
  logic       tx, busy, done, frame_err, parity_err, timeout;
  logic [7:0] result;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0] a, b;
    logic [5:0] op;
    logic [7:0] rx_byte;
    logic       rx_par, rx_stop, glitch;
    logic [7:0] exp_result;
    logic       exp_frame, exp_par;
  } vec_t;
  vec_t vecs[5];

  uart_host_seq dut (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_start(start),
    .i_datoa(data_a), .i_datob(data_b), .i_opcode(opcode),
    .i_rx_data_input(rx), .o_tx_data(tx), .o_busy(busy), .o_done(done),
    .o_result(result), .o_frame_err(frame_err), .o_parity_err(parity_err),
    .o_timeout(timeout), .o_dbg_state(dbg_state)
  );

  // Clock and baud tick: one tick every second clock cycle.
  always #5 clk = ~clk;
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = ~tick;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns just after the negedge whose tick is consumed by the next posedge.
  task automatic next_tick();
    int guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (!tick && guard < 8);
    if (!tick) check("tick_wait", 0, 1);
  endtask

  task automatic send_start(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    @(negedge clk);
    #1;
    while (tick) begin
      @(negedge clk);
      #1;
    end
    data_a = a; data_b = b; opcode = op; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(^d);
    exp_q.push_back(1'b1);
  endtask

  // Checks nbits line levels, each held 16 ticks; optionally pulses i_start while busy.
  task automatic check_tx(input int nbits, input int pulse_bit);
    logic [0:0] e;
    logic act;
    for (int k = 0; k < nbits; k++) begin
      e = exp_q.pop_front();
      act = e[0];
      for (int t = 0; t < 16; t++) begin
        next_tick();
        if (tx !== e[0]) act = tx;
        if (k == pulse_bit && t == 0) begin
          @(posedge clk);
          #1;
          data_a = 8'h99; data_b = 8'h99; opcode = 6'h3F; start = 1'b1;
          @(negedge clk);
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
      check($sformatf("tx_bit%0d", k), {31'd0, act}, {31'd0, e[0]});
    end
  endtask

  task automatic send_reply(input logic [7:0] d, input logic par, input logic stop, input logic glitch);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    repeat (5) next_tick();
    if (glitch) begin
      repeat (4) begin next_tick(); rx = 1'b0; end
      next_tick(); rx = 1'b1;
      repeat (20) next_tick();
    end
    for (int k = 0; k < 11; k++)
      repeat (16) begin next_tick(); rx = bits[k]; end
    next_tick();
    rx = 1'b1;
  endtask

  task automatic wait_done(input int limit, output logic seen, output int ticks,
                           output logic done_after, output logic busy_after);
    seen = 1'b0; ticks = 0; done_after = 1'b1; busy_after = 1'b1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (tick) ticks++;
    end
    if (seen) begin
      @(negedge clk);
      #1;
      done_after = done;
      busy_after = busy;
    end
  endtask

  initial begin
    logic seen, done_after, busy_after, stuck;
    int ticks;

    vecs[0] = '{8'h02, 8'h04, 6'h20, 8'h06, 1'b0, 1'b1, 1'b0, 8'h06, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 8'h3C, 6'h3F, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0};
    vecs[2] = '{8'h02, 8'h04, 6'h20, 8'h06, 1'b1, 1'b1, 1'b0, 8'h06, 1'b0, PCHK};
    vecs[3] = '{8'hFF, 8'h00, 6'h01, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
    vecs[4] = '{8'h10, 8'h20, 6'h05, 8'h37, 1'b1, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; rx = 1'b1;
    data_a = '0; data_b = '0; opcode = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_result", {24'd0, result}, 0);
    check("rst_flags", {29'd0, frame_err, parity_err, timeout}, 0);
    check("rst_state", {28'd0, dbg_state}, 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      send_start(vecs[v].a, vecs[v].b, vecs[v].op);
      check($sformatf("v%0d_busy", v), {31'd0, busy}, 1);
      push_frame(vecs[v].a);
      push_frame(vecs[v].b);
      push_frame({2'b00, vecs[v].op});
      check_tx(33, -1);
      fork
        send_reply(vecs[v].rx_byte, vecs[v].rx_par, vecs[v].rx_stop, vecs[v].glitch);
        wait_done(2000, seen, ticks, done_after, busy_after);
      join
      check($sformatf("v%0d_done_seen", v), {31'd0, seen}, 1);
      check($sformatf("v%0d_done_width", v), {31'd0, done_after}, 0);
      check($sformatf("v%0d_busy_low", v), {31'd0, busy_after}, 0);
      check($sformatf("v%0d_result", v), {24'd0, result}, {24'd0, vecs[v].exp_result});
      check($sformatf("v%0d_frame_err", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_frame});
      check($sformatf("v%0d_parity_err", v), {31'd0, parity_err}, {31'd0, vecs[v].exp_par});
      check($sformatf("v%0d_timeout", v), {31'd0, timeout}, 0);
    end

    // No reply: timeout after 64 bit-times, previous result kept.
    send_start(8'h02, 8'h04, 6'h20);
    push_frame(8'h02); push_frame(8'h04); push_frame(8'h20);
    check_tx(33, -1);
    wait_done(4000, seen, ticks, done_after, busy_after);
    check("to_done_seen", {31'd0, seen}, 1);
    check("to_ticks", ticks, 1024);
    check("to_timeout", {31'd0, timeout}, 1);
    check("to_result_kept", {24'd0, result}, 32'h37);
    check("to_other_flags", {30'd0, frame_err, parity_err}, 0);
    check("to_done_width", {31'd0, done_after}, 0);
    check("to_busy_low", {31'd0, busy_after}, 0);

    // Busy-time i_start ignored, then reset during frame 2 data bits.
    send_start(8'h11, 8'h22, 6'h05);
    push_frame(8'h11); push_frame(8'h22); push_frame(8'h05);
    check_tx(15, 2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_tx", {31'd0, tx}, 1);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_result", {24'd0, result}, 0);
    check("mid_rst_flags", {29'd0, frame_err, parity_err, timeout}, 0);
    rst = 1'b0;
    exp_q.delete();
    stuck = 1'b0;
    repeat (400) begin
      @(negedge clk);
      #1;
      if (busy !== 1'b0 || tx !== 1'b1) stuck = 1'b1;
    end
    check("no_second_txn", {31'd0, stuck}, 0);

    // Reset and start in the same cycle: request dropped.
    @(negedge clk);
    #1;
    rst = 1'b1; start = 1'b1; data_a = 8'h55; data_b = 8'hAA; opcode = 6'h01;
    @(negedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    stuck = 1'b0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (busy !== 1'b0 || tx !== 1'b1) stuck = 1'b1;
    end
    check("rst_beats_start", {31'd0, stuck}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
